// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch unit. Issues one word-aligned fetch at a
// time toward instruction memory, buffers returned words with their byte
// addresses in a small FIFO, and flushes/refetches on a branch redirect.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0]      WORD_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        req_pc;
    logic [31:0]        fifo_inst [DEPTH];
    logic [31:0]        fifo_pc   [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [31:0]        redirect_addr;

    // The low two bits of a redirect target are dropped so every fetch is word aligned.
    assign redirect_addr = redirect_pc & WORD_MASK;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // A new fetch may only leave while nothing is outstanding and there is room
    // for its response; a redirect in the same cycle suppresses it so the stale
    // address is never accepted.
    assign imem_req  = ~reset & (state == IDLE) & ~full & ~redirect;
    assign imem_addr = fetch_pc;

    // Responses are kept only in WAIT; a redirect in the same cycle discards them.
    assign push = (state == WAIT) & imem_rvalid & ~redirect;

    // Decode sees nothing while a redirect is flushing the queue.
    assign inst_valid = ~empty & ~redirect;
    assign pop        = inst_valid & inst_ready;
    assign inst       = empty ? '0 : fifo_inst[rd_ptr];
    assign inst_pc    = empty ? '0 : fifo_pc[rd_ptr];

    // Fetch sequencer: tracks the single outstanding request and the next fetch address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC & WORD_MASK;
            req_pc   <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_addr;
            if (state == IDLE || imem_rvalid) begin
                state <= IDLE;
            end else begin
                state <= DROP;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (imem_req && imem_ready) begin
                        state    <= WAIT;
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Queue bookkeeping: pointers and occupancy, cleared outright on redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a
// queue-based behavioural model of the prefetcher and a simple memory responder.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    bit          outstanding;
    bit          discard;
    int          delay;
    int          lat_min;
    int          lat_max;
    int          checks;
    int          failures;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_fetch_pc  = RESET_PC & 32'hFFFF_FFFC;
        outstanding = 0;
        discard     = 0;
        delay       = 0;
    endtask

    // Holds reset across one rising edge, checks the reset outputs, then releases.
    task automatic doReset();
        @(negedge clk);
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        #1;
        checkOutput("rst_req", imem_req, 0);
        checkOutput("rst_valid", inst_valid, 0);
        checkOutput("rst_inst", inst, 0);
        checkOutput("rst_pc", inst_pc, 0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rel_req", imem_req, 1);
        checkOutput("rel_addr", imem_addr, RESET_PC);
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic applyStimulus(input bit ready, input bit rdy, input bit redir,
                                 input logic [31:0] rpc, input bit spurious);
        bit          rv;
        bit          real_rv;
        bit          m_req;
        bit          m_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        @(negedge clk);
        real_rv     = outstanding && (delay == 0);
        rv          = real_rv || (spurious && !outstanding);
        imem_ready  = ready;
        imem_rvalid = rv;
        imem_rdata  = real_rv ? out_data : $urandom;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        m_req    = !outstanding && (q.size() < DEPTH) && !redir;
        m_valid  = (q.size() != 0) && !redir;
        exp_inst = (q.size() != 0) ? q[0].word : 32'h0;
        exp_pc   = (q.size() != 0) ? q[0].pc   : 32'h0;
        checkOutput("imem_req", imem_req, m_req);
        if (m_req) checkOutput("imem_addr", imem_addr, m_fetch_pc);
        checkOutput("inst_valid", inst_valid, m_valid);
        checkOutput("inst", inst, exp_inst);
        checkOutput("inst_pc", inst_pc, exp_pc);

        if (outstanding && delay > 0) delay--;
        if (redir) begin
            q.delete();
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
            if (outstanding) begin
                if (real_rv) outstanding = 0;
                else         discard = 1;
            end
        end else begin
            if (m_valid && rdy) void'(q.pop_front());
            if (real_rv) begin
                if (!discard) q.push_back('{pc: out_addr, word: out_data});
                outstanding = 0;
                discard     = 0;
            end else if (m_req && ready) begin
                outstanding = 1;
                discard     = 0;
                out_addr    = m_fetch_pc;
                out_data    = $urandom;
                delay       = $urandom_range(lat_max, lat_min);
                m_fetch_pc  = m_fetch_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic [31:0] pcs [4];
        int          npop;
        bit          seen_req;
        bit          seen_inst;
        bit          reached;
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        lat_min     = 0;
        lat_max     = 0;

        // Streaming after reset: pcs 0,4,8,12 in order.
        doReset();
        for (int k = 0; k < 4; k++) pcs[k] = 32'hDEAD_BEEF;
        npop = 0;
        for (int i = 0; i < 40 && npop < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            if (inst_valid && inst_ready) begin
                pcs[npop] = inst_pc;
                npop++;
            end
        end
        checkOutput("seq_count", npop, 4);
        for (int k = 0; k < 4; k++) checkOutput("seq_pc", pcs[k], 32'(k * 4));

        // Stalled decode: queue fills to DEPTH, requests stop, resume at 16.
        doReset();
        for (int i = 0; i < 30; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("full_req", imem_req, 0);
        checkOutput("full_valid", inst_valid, 1);
        checkOutput("full_head", inst_pc, 0);
        seen_req = 0;
        for (int i = 0; i < 10 && !seen_req; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            if (imem_req) begin
                seen_req = 1;
                checkOutput("resume_addr", imem_addr, 32'h10);
            end
        end
        checkOutput("resume_seen", seen_req, 1);

        // Redirect while waiting on address 8: its response is dropped.
        doReset();
        lat_min = 2;
        lat_max = 2;
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            reached = outstanding && (out_addr == 32'h8) && (delay > 0);
        end
        checkOutput("wait8_reached", reached, 1);
        applyStimulus(1, 1, 1, 32'h103, 0);
        seen_req  = 0;
        seen_inst = 0;
        for (int i = 0; i < 20 && !seen_inst; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            if (imem_req && !seen_req) begin
                seen_req = 1;
                checkOutput("redir_addr", imem_addr, 32'h100);
            end
            if (inst_valid && !seen_inst) begin
                seen_inst = 1;
                checkOutput("redir_pc", inst_pc, 32'h100);
            end
        end
        checkOutput("redir_seen", seen_inst, 1);

        // Redirect coinciding with a response and a pop while two entries are queued.
        doReset();
        lat_min = 0;
        lat_max = 0;
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            reached = (q.size() == 2) && outstanding;
        end
        checkOutput("cnt2_reached", reached, 1);
        applyStimulus(1, 1, 1, 32'h200, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("flush_valid", inst_valid, 0);
        checkOutput("flush_req", imem_req, 1);
        checkOutput("flush_addr", imem_addr, 32'h200);

        // Fetch address wraps from the top of memory to 0.
        applyStimulus(1, 1, 1, 32'hFFFF_FFFC, 0);
        npop = 0;
        for (int k = 0; k < 2; k++) pcs[k] = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && npop < 2; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            if (inst_valid && inst_ready) begin
                pcs[npop] = inst_pc;
                npop++;
            end
        end
        checkOutput("wrap_pc0", pcs[0], 32'hFFFF_FFFC);
        checkOutput("wrap_pc1", pcs[1], 32'h0);

        // Reset while a request is outstanding; its late response must be ignored.
        doReset();
        lat_min = 3;
        lat_max = 3;
        reached = 0;
        for (int i = 0; i < 10 && !reached; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            reached = outstanding && !discard;
        end
        checkOutput("wait_reached", reached, 1);
        doReset();
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("late_valid", inst_valid, 0);
        checkOutput("late_req", imem_req, 1);
        checkOutput("late_addr", imem_addr, RESET_PC);
        lat_min = 0;
        lat_max = 0;
        seen_inst = 0;
        for (int i = 0; i < 10 && !seen_inst; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            if (inst_valid) begin
                seen_inst = 1;
                checkOutput("late_first_pc", inst_pc, RESET_PC);
            end
        end
        checkOutput("late_first_seen", seen_inst, 1);

        // Randomized traffic with stalls, variable latency, redirects and stray responses.
        lat_min = 0;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            applyStimulus($urandom_range(9, 0) < 7,
                          $urandom_range(9, 0) < 6,
                          $urandom_range(19, 0) == 0,
                          rpc,
                          $urandom_range(19, 0) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
